// File: rtl/round_pkg.sv
// Shared types and default constants for the switch-game round controller.
package round_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ROUND     = 2'd1,
    GAP       = 2'd2,
    GAME_OVER = 2'd3
  } round_state_e;

  localparam logic [5:0] ROUND_TIME_D   = 6'd15;
  localparam logic [5:0] GAP_TIME_D     = 6'd5;
  localparam logic [1:0] LIVES_D        = 2'd3;
  localparam logic [9:0] SCORE_MAX_D    = 10'd999;
  localparam logic [1:0] MULT_SHIFT_MAX = 2'd3;
  localparam logic [6:0] PASSES_MAX     = 7'd127;
  localparam logic [6:0] ROUND_NUM_MAX  = 7'd99;
  localparam logic [5:0] ROUND_TIME_MIN = 6'd5;

  // Multiplier exponent: one step per five passes, capped at MULT_SHIFT_MAX.
  function automatic logic [1:0] mult_shift(input logic [6:0] passes);
    logic [1:0] sh;
    if (passes >= 7'd15) begin
      sh = MULT_SHIFT_MAX;
    end else if (passes >= 7'd10) begin
      sh = 2'd2;
    end else if (passes >= 7'd5) begin
      sh = 2'd1;
    end else begin
      sh = 2'd0;
    end
    return sh;
  endfunction

endpackage

// File: rtl/round_controller_score_accum.sv
// Pass counter and saturating score accumulator; each pass earns 2*mult
// points where mult doubles every fifth pass up to 8.
module score_accum
  import round_pkg::*;
#(
  parameter logic [9:0] SCORE_MAX = SCORE_MAX_D
) (
  input  logic       clk1Hz,
  input  logic       reset_btn,
  input  logic       add_pulse,
  input  logic       clear,
  output logic [9:0] score,
  output logic [6:0] passes
);

  logic [4:0]  award_s;
  logic [10:0] sum_s;

  // Points for the pass being scored, based on passes before this one.
  always_comb begin
    award_s = 5'd2 << mult_shift(passes);
    sum_s   = {1'b0, score} + {6'd0, award_s};
  end

  // Score and pass count registers.
  always_ff @(posedge clk1Hz or posedge reset_btn) begin
    if (reset_btn) begin
      score  <= 10'd0;
      passes <= 7'd0;
    end else if (clear) begin
      score  <= 10'd0;
      passes <= 7'd0;
    end else if (add_pulse) begin
      if (sum_s > {1'b0, SCORE_MAX}) begin
        score <= SCORE_MAX;
      end else begin
        score <= sum_s[9:0];
      end
      if (passes != PASSES_MAX) begin
        passes <= passes + 7'd1;
      end else begin
        passes <= passes;
      end
    end else begin
      score  <= score;
      passes <= passes;
    end
  end

endmodule

// File: rtl/round_controller.sv
// Round sequencer for the switch game: IDLE -> ROUND <-> GAP -> GAME_OVER.
// Optional feature macro ROUND_SPEEDUP_EN shortens rounds as passes accumulate.
module round_controller
  import round_pkg::*;
#(
  parameter logic [5:0] ROUND_TIME = ROUND_TIME_D,
  parameter logic [5:0] GAP_TIME   = GAP_TIME_D,
  parameter logic [1:0] LIVES      = LIVES_D,
  parameter logic [9:0] SCORE_MAX  = SCORE_MAX_D
) (
  input  logic       clk1Hz,
  input  logic       reset_btn,
  input  logic       start,
  input  logic       is_correct,
  output logic [5:0] count,
  output logic       in_round,
  output logic       prompt_req,
  output logic [6:0] round_num,
  output logic [9:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  round_state_e state_r;
  logic         add_pulse_s;
  logic         clear_s;
  logic [6:0]   passes_s;
  logic [5:0]   round_time_s;

  score_accum #(
    .SCORE_MAX (SCORE_MAX)
  ) u_score_accum (
    .clk1Hz    (clk1Hz),
    .reset_btn (reset_btn),
    .add_pulse (add_pulse_s),
    .clear     (clear_s),
    .score     (score),
    .passes    (passes_s)
  );

  // Scoring strobes: clear on game start, add on a pass during ROUND.
  always_comb begin
    add_pulse_s = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      IDLE:    clear_s     = start;
      ROUND:   add_pulse_s = is_correct;
      default: begin
        add_pulse_s = 1'b0;
        clear_s     = 1'b0;
      end
    endcase
  end

`ifdef ROUND_SPEEDUP_EN
  logic [4:0] cut_s;

  // Round length: one second less per five passes, floored at ROUND_TIME_MIN.
  always_comb begin
    cut_s = 5'(passes_s / 7'd5);
    if ({1'b0, ROUND_TIME} < ({2'b00, cut_s} + 7'd5)) begin
      round_time_s = ROUND_TIME_MIN;
    end else begin
      round_time_s = ROUND_TIME - {1'b0, cut_s};
    end
  end
`else
  logic unused_passes_s;

  // Fixed round length; the pass count only matters to the score here.
  always_comb begin
    round_time_s    = ROUND_TIME;
    unused_passes_s = ^passes_s;
  end
`endif

  // Main FSM with all registered outputs.
  always_ff @(posedge clk1Hz or posedge reset_btn) begin
    if (reset_btn) begin
      state_r    <= IDLE;
      count      <= 6'd0;
      in_round   <= 1'b0;
      prompt_req <= 1'b0;
      round_num  <= 7'd0;
      lives      <= LIVES;
      game_over  <= 1'b0;
    end else begin
      prompt_req <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= ROUND;
            count      <= round_time_s;
            in_round   <= 1'b1;
            prompt_req <= 1'b1;
            round_num  <= 7'd1;
            lives      <= LIVES;
          end else begin
            state_r <= IDLE;
          end
        end
        ROUND: begin
          // A pass outranks timeout, so a verdict on the last second still counts.
          if (is_correct) begin
            state_r  <= GAP;
            count    <= GAP_TIME;
            in_round <= 1'b0;
          end else if (count == 6'd0) begin
            in_round <= 1'b0;
            if (lives == 2'd1) begin
              state_r   <= GAME_OVER;
              count     <= 6'd0;
              lives     <= 2'd0;
              game_over <= 1'b1;
            end else begin
              state_r <= GAP;
              count   <= GAP_TIME;
              lives   <= lives - 2'd1;
            end
          end else begin
            count <= count - 6'd1;
          end
        end
        GAP: begin
          if (count == 6'd0) begin
            state_r    <= ROUND;
            count      <= round_time_s;
            in_round   <= 1'b1;
            prompt_req <= 1'b1;
            if (round_num != ROUND_NUM_MAX) begin
              round_num <= round_num + 7'd1;
            end else begin
              round_num <= round_num;
            end
          end else begin
            count <= count - 6'd1;
          end
        end
        GAME_OVER: begin
          state_r <= GAME_OVER;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Scoreboard bench for round_controller: a rule-level game model predicts every
// cycle's outputs; a monitor pops and compares them away from the clock edge.
module tb_round_controller;

  localparam int RT   = 15;
  localparam int GT   = 5;
  localparam int LV   = 3;
  localparam int SMAX = 999;
  localparam int PH_IDLE = 0, PH_ROUND = 1, PH_GAP = 2, PH_OVER = 3;

  logic       clk1Hz     = 1'b0;
  logic       reset_btn  = 1'b0;
  logic       start      = 1'b0;
  logic       is_correct = 1'b0;
  logic [5:0] count;
  logic       in_round;
  logic       prompt_req;
  logic [6:0] round_num;
  logic [9:0] score;
  logic [1:0] lives;
  logic       game_over;

  round_controller dut (
    .clk1Hz     (clk1Hz),
    .reset_btn  (reset_btn),
    .start      (start),
    .is_correct (is_correct),
    .count      (count),
    .in_round   (in_round),
    .prompt_req (prompt_req),
    .round_num  (round_num),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clk1Hz = ~clk1Hz;

  typedef struct {
    int count;
    int in_round;
    int prompt_req;
    int round_num;
    int score;
    int lives;
    int game_over;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;

  int m_phase, m_count, m_in_round, m_prompt, m_round;
  int m_score, m_lives, m_over, m_passes;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int round_time();
`ifdef ROUND_SPEEDUP_EN
    int t;
    t = RT - m_passes / 5;
    return (t < 5) ? 5 : t;
`else
    return RT;
`endif
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_count = 0; m_in_round = 0; m_prompt = 0; m_round = 0;
    m_score = 0; m_lives = LV; m_over = 0; m_passes = 0;
  endtask

  task automatic model_edge(input bit st, input bit ic);
    int sh;
    m_prompt = 0;
    case (m_phase)
      PH_IDLE: if (st) begin
        m_passes = 0; m_score = 0; m_round = 1; m_lives = LV;
        m_count = round_time(); m_phase = PH_ROUND; m_in_round = 1; m_prompt = 1;
      end
      PH_ROUND: begin
        if (ic) begin
          sh = m_passes / 5;
          if (sh > 3) sh = 3;
          m_score = (m_score + (2 << sh) > SMAX) ? SMAX : m_score + (2 << sh);
          if (m_passes < 127) m_passes++;
          m_phase = PH_GAP; m_count = GT; m_in_round = 0;
        end else if (m_count == 0) begin
          m_lives--;
          m_in_round = 0;
          if (m_lives == 0) begin
            m_phase = PH_OVER; m_count = 0; m_over = 1;
          end else begin
            m_phase = PH_GAP; m_count = GT;
          end
        end else begin
          m_count--;
        end
      end
      PH_GAP: begin
        if (m_count == 0) begin
          m_phase = PH_ROUND; m_count = round_time(); m_in_round = 1; m_prompt = 1;
          if (m_round < 99) m_round++;
        end else begin
          m_count--;
        end
      end
      default: ;
    endcase
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.count = m_count; s.in_round = m_in_round; s.prompt_req = m_prompt;
    s.round_num = m_round; s.score = m_score; s.lives = m_lives; s.game_over = m_over;
    return s;
  endfunction

  // Monitor: compares once per negedge, and right after an asynchronous reset.
  always begin
    @(negedge clk1Hz or posedge reset_btn);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("count",      int'(count),      mon_e.count);
      check("in_round",   int'(in_round),   mon_e.in_round);
      check("prompt_req", int'(prompt_req), mon_e.prompt_req);
      check("round_num",  int'(round_num),  mon_e.round_num);
      check("score",      int'(score),      mon_e.score);
      check("lives",      int'(lives),      mon_e.lives);
      check("game_over",  int'(game_over),  mon_e.game_over);
    end
  end

  task automatic step(input bit st, input bit ic);
    start = st;
    is_correct = ic;
    @(posedge clk1Hz);
    model_edge(st, ic);
    exp_q.push_back(model_snap());
    #1;
  endtask

  // Reset pulse placed between clock edges; checked before the next posedge.
  task automatic do_reset();
    @(negedge clk1Hz);
    #2;
    start = 1'b0;
    is_correct = 1'b0;
    reset_btn = 1'b1;
    model_reset();
    exp_q.push_back(model_snap());
    #2;
    reset_btn = 1'b0;
  endtask

  task automatic play_round(input int pass_at);
    for (int k = 1; k <= 40; k++) begin
      if (m_phase != PH_ROUND) break;
      step(1'b0, k == pass_at);
    end
  endtask

  task automatic play_gap();
    for (int k = 0; k < 40; k++) begin
      if (m_phase != PH_GAP) break;
      step(1'b0, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("prompt_on_start", int'(prompt_req), 1);
    check("count_on_start", int'(count), RT);

    play_round(3);
    check("score_first_pass", int'(score), 2);
    check("gap_count_load", int'(count), GT);
    play_gap();
    check("round_num_2", int'(round_num), 2);
    check("prompt_round_2", int'(prompt_req), 1);

    play_round(16);
    check("lives_after_tie", int'(lives), 3);
    check("score_after_tie", int'(score), 4);
    play_gap();
    play_round(0);
    check("lives_after_timeout", int'(lives), 2);
    play_gap();
    play_round(2);
    play_gap();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("score_before_reset", int'(score), 6);
    do_reset();
    step(1'b1, 1'b0);
    check("score_after_restart", int'(score), 0);
    check("round_after_restart", int'(round_num), 1);

    for (int i = 1; i <= 11; i++) begin
      play_round(int'($urandom_range(1, 16)));
      if (i == 5)  check("score_5_passes", int'(score), 10);
      if (i == 10) check("score_10_passes", int'(score), 30);
      if (i == 11) check("score_11_passes", int'(score), 38);
      play_gap();
    end
`ifdef ROUND_SPEEDUP_EN
    for (int i = 12; i <= 50; i++) begin
      play_round(1);
      play_gap();
    end
    check("speedup_floor", int'(count), 5);
`endif

    for (int i = 0; i < 3; i++) begin
      play_round(0);
      play_gap();
    end
    check("game_over_flag", int'(game_over), 1);
    check("lives_at_game_over", int'(lives), 0);
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    @(negedge clk1Hz);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
